// File: rtl/mmu_port_arbiter.sv
// Two-requester front end for one byte-wide SimpleMmu port: opcode fetch on port 0, data
// load/store on port 1. Requests are latched per port and served one at a time, round-robin.
module mmu_port_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BUSY_WAIT     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [7:0]               wdata0,
    input  logic [7:0]               wdata1,
    input  logic                     lock0,
    input  logic                     lock1,
    output logic                     busy0,
    output logic                     busy1,
    output logic [7:0]               rdata0,
    output logic [7:0]               rdata1,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_we,
    output logic [7:0]               mem_wdata,
    output logic                     mem_request,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_busy
);

    localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               pend_q, pend_d;
    logic                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [1:0][7:0]          rdata_q, rdata_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                     mem_we_q, mem_we_d;
    logic [7:0]               mem_wdata_q, mem_wdata_d;

    logic [ADDRESS_WIDTH-1:0] slot_addr_q [2];
    logic [1:0]               slot_we_q;
    logic [7:0]               slot_wdata_q [2];

    logic [1:0] accept;
    logic [1:0] lock_v;
    logic       grant_valid;
    logic       grant_port;
    logic       complete;

    assign accept = {req1, req0} & ~pend_q;
    assign lock_v = {lock1, lock0};

    // NOTE: slot payload needs no reset; a slot is only read while its pending bit is set.
    always_ff @(posedge clk) begin
        if (accept[0]) begin
            slot_addr_q[0]  <= addr0;
            slot_we_q[0]    <= we0;
            slot_wdata_q[0] <= wdata0;
        end
        if (accept[1]) begin
            slot_addr_q[1]  <= addr1;
            slot_we_q[1]    <= we1;
            slot_wdata_q[1] <= wdata1;
        end
    end

    // A lock only binds when its port owned the previous access, so a burst continues unbroken.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        if (lock_v[last_q]) begin
            grant_valid = pend_q[last_q];
            grant_port  = last_q;
        end else if (&pend_q) begin
            grant_valid = 1'b1;
            grant_port  = ~last_q;
        end else if (pend_q[0]) begin
            grant_valid = 1'b1;
            grant_port  = 1'b0;
        end else if (pend_q[1]) begin
            grant_valid = 1'b1;
            grant_port  = 1'b1;
        end
    end

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        complete    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d     = ISSUE;
                    owner_d     = grant_port;
                    last_d      = grant_port;
                    mem_addr_d  = slot_addr_q[grant_port];
                    mem_we_d    = slot_we_q[grant_port];
                    mem_wdata_d = slot_wdata_q[grant_port];
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: begin
                if (mem_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!mem_busy) begin
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            state_d = IDLE;
            if (!mem_we_q) begin
                rdata_d[owner_q] = mem_rdata;
            end
        end

        pend_d = pend_q | accept;
        if (complete) begin
            pend_d[owner_q] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy0       = pend_q[0];
    assign busy1       = pend_q[1];
    assign rdata0      = rdata_q[0];
    assign rdata1      = rdata_q[1];
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_request = (state_q == ISSUE);

endmodule
